// File: rtl/ledpanel_pkg.sv
// Shared geometry, scan states and pixel layout for the LED panel scan-out driver.
package ledpanel_pkg;

    localparam int unsigned PANEL_W   = 32;
    localparam int unsigned HALF_ROWS = 16;
    localparam int unsigned COL_W     = $clog2(PANEL_W);
    localparam int unsigned ROW_W     = $clog2(HALF_ROWS);
    localparam int unsigned FB_ADDR_W = ROW_W + COL_W;
    localparam int unsigned RGB_W     = 24;

    localparam int unsigned R_LSB = 16;
    localparam int unsigned G_LSB = 8;
    localparam int unsigned B_LSB = 0;

    typedef enum logic [1:0] {
        FETCH,
        SHIFT,
        LATCH,
        DISPLAY
    } scan_state_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    // {R,G,B} bit at position idx within each 8-bit channel
    function automatic logic [2:0] rgb_plane_bits(input rgb_t px, input logic [2:0] idx);
        logic [RGB_W-1:0] w;
        w = px;
        return {w[5'(R_LSB) + 5'(idx)], w[5'(G_LSB) + 5'(idx)], w[5'(B_LSB) + 5'(idx)]};
    endfunction

endpackage

// File: rtl/ledpanel_fb.sv
// Dual-bank 32x32 RGB frame buffer: bank per panel half, one write port, one
// synchronous read-before-write port reading both banks at the same row/column.
module ledpanel_fb
    import ledpanel_pkg::*;
(
    input  logic             clk,
    input  logic             wr_enable,
    input  logic [COL_W-1:0] wr_addr_x,
    input  logic [ROW_W:0]   wr_addr_y,
    input  rgb_t             wr_data,
    input  logic [ROW_W-1:0] rd_row,
    input  logic [COL_W-1:0] rd_col,
    output rgb_t             rd_top,
    output rgb_t             rd_bot
);

    localparam int unsigned BANK_DEPTH = HALF_ROWS * PANEL_W;

    rgb_t bank_top [BANK_DEPTH];
    rgb_t bank_bot [BANK_DEPTH];

    logic [FB_ADDR_W-1:0] wr_addr;
    logic [FB_ADDR_W-1:0] rd_addr;

    assign wr_addr = {wr_addr_y[ROW_W-1:0], wr_addr_x};
    assign rd_addr = {rd_row, rd_col};

    // Read data is captured before the same-edge write lands (old data wins)
    always_ff @(posedge clk) begin
        rd_top <= bank_top[rd_addr];
        if (wr_enable && !wr_addr_y[ROW_W]) begin
            bank_top[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        rd_bot <= bank_bot[rd_addr];
        if (wr_enable && wr_addr_y[ROW_W]) begin
            bank_bot[wr_addr] <= wr_data;
        end
    end

endmodule

// File: rtl/ledpanel_scan.sv
// HUB75 scan-out driver: 1/16 scan with binary-coded modulation over BITS
// colour planes, refreshing the panel continuously from ledpanel_fb.
module ledpanel_scan
    import ledpanel_pkg::*;
#(
    parameter int unsigned BITS       = 4,
    parameter int unsigned BASE_TICKS = 8
) (
    input  logic             CLK12MHZ,
    input  logic             resetn,
    input  logic             wr_enable,
    input  logic [COL_W-1:0] wr_addr_x,
    input  logic [ROW_W:0]   wr_addr_y,
    input  logic [RGB_W-1:0] wr_rgb_data,
    output logic             PANEL_R0,
    output logic             PANEL_G0,
    output logic             PANEL_B0,
    output logic             PANEL_R1,
    output logic             PANEL_G1,
    output logic             PANEL_B1,
    output logic             PANEL_A,
    output logic             PANEL_B,
    output logic             PANEL_C,
    output logic             PANEL_D,
    output logic             PANEL_CLK,
    output logic             PANEL_STB,
    output logic             PANEL_OE,
    output logic             frame_done
);

    localparam int unsigned PLANE_W   = (BITS > 1) ? $clog2(BITS) : 1;
    localparam int unsigned PLANE_LSB = 8 - BITS;
    localparam int unsigned MAX_TICKS = BASE_TICKS << (BITS - 1);
    localparam int unsigned TICK_W    = $clog2(MAX_TICKS + 1);

    scan_state_t state_q, state_d;

    logic [COL_W-1:0]   col_q;
    logic               phase_q;
    logic [ROW_W-1:0]   row_q;
    logic [PLANE_W-1:0] plane_q;
    logic [TICK_W-1:0]  tick_q;

    logic last_col, last_row, last_plane, last_tick;
    logic [2:0] bit_idx;

    rgb_t             rd_top, rd_bot;
    logic [COL_W-1:0] rd_col;

    logic [2:0]       top_bits_q, top_bits_d;
    logic [2:0]       bot_bits_q, bot_bits_d;
    logic [ROW_W-1:0] row_sel_q, row_sel_d;
    logic             oe_q, oe_d;
    logic             stb_q, stb_d;
    logic             pclk_q, pclk_d;
    logic             done_q, done_d;

    assign last_col   = (col_q == COL_W'(PANEL_W - 1));
    assign last_row   = (row_q == ROW_W'(HALF_ROWS - 1));
    assign last_plane = (plane_q == PLANE_W'(BITS - 1));
    assign last_tick  = (tick_q == TICK_W'((BASE_TICKS << plane_q) - 1));
    assign bit_idx    = 3'(PLANE_LSB) + 3'(plane_q);

    // Prefetch: FETCH reads x=0, each SHIFT pixel reads x+1 for the next one
    assign rd_col = (state_q == SHIFT) ? col_q + COL_W'(1) : '0;

    ledpanel_fb u_fb (
        .clk       (CLK12MHZ),
        .wr_enable (wr_enable),
        .wr_addr_x (wr_addr_x),
        .wr_addr_y (wr_addr_y),
        .wr_data   (wr_rgb_data),
        .rd_row    (row_q),
        .rd_col    (rd_col),
        .rd_top    (rd_top),
        .rd_bot    (rd_bot)
    );

    always_ff @(posedge CLK12MHZ) begin
        if (!resetn) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH:   state_d = SHIFT;
            SHIFT:   if (phase_q && last_col) state_d = LATCH;
            LATCH:   state_d = DISPLAY;
            DISPLAY: if (last_tick) state_d = FETCH;
            default: state_d = FETCH;
        endcase
    end

    // Pixel/phase, plane, row and display-tick counters
    always_ff @(posedge CLK12MHZ) begin
        if (!resetn) begin
            col_q   <= '0;
            phase_q <= 1'b0;
            row_q   <= '0;
            plane_q <= '0;
            tick_q  <= '0;
        end else begin
            case (state_q)
                FETCH: begin
                    col_q   <= '0;
                    phase_q <= 1'b0;
                end
                SHIFT: begin
                    phase_q <= ~phase_q;
                    if (phase_q) col_q <= col_q + COL_W'(1);
                end
                LATCH: tick_q <= '0;
                DISPLAY: begin
                    tick_q <= tick_q + TICK_W'(1);
                    if (last_tick) begin
                        if (last_plane) begin
                            plane_q <= '0;
                            row_q   <= row_q + ROW_W'(1);
                        end else begin
                            plane_q <= plane_q + PLANE_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        top_bits_d = top_bits_q;
        bot_bits_d = bot_bits_q;
        row_sel_d  = row_sel_q;
        oe_d       = 1'b1;
        stb_d      = 1'b0;
        pclk_d     = 1'b0;
        done_d     = 1'b0;
        case (state_q)
            SHIFT: begin
                if (!phase_q) begin
                    top_bits_d = rgb_plane_bits(rd_top, bit_idx);
                    bot_bits_d = rgb_plane_bits(rd_bot, bit_idx);
                end else begin
                    pclk_d = 1'b1;
                end
            end
            LATCH: begin
                stb_d     = 1'b1;
                row_sel_d = row_q;
            end
            DISPLAY: begin
                oe_d   = 1'b0;
                done_d = last_tick && last_row && last_plane;
            end
            default: ;
        endcase
    end

    // Pin registers: data changes with the falling shift clock, stable at its rise
    always_ff @(posedge CLK12MHZ) begin
        if (!resetn) begin
            top_bits_q <= '0;
            bot_bits_q <= '0;
            row_sel_q  <= '0;
            oe_q       <= 1'b1;
            stb_q      <= 1'b0;
            pclk_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            top_bits_q <= top_bits_d;
            bot_bits_q <= bot_bits_d;
            row_sel_q  <= row_sel_d;
            oe_q       <= oe_d;
            stb_q      <= stb_d;
            pclk_q     <= pclk_d;
            done_q     <= done_d;
        end
    end

    assign {PANEL_R0, PANEL_G0, PANEL_B0}         = top_bits_q;
    assign {PANEL_R1, PANEL_G1, PANEL_B1}         = bot_bits_q;
    assign {PANEL_D, PANEL_C, PANEL_B, PANEL_A}   = row_sel_q;
    assign PANEL_OE   = oe_q;
    assign PANEL_STB  = stb_q;
    assign PANEL_CLK  = pclk_q;
    assign frame_done = done_q;

endmodule

// File: doc/ledpanel_scan.md
# ledpanel_scan

Scan-out driver for the 32x32 HUB75-style LED panel: owns a 24-bit RGB frame buffer written by the CPU memory/IO decoder (one pixel per `wr_enable` pulse) and continuously refreshes the panel with binary-coded modulation. It sits directly downstream of the CPU's `0x1000_0000` write decode and drives the panel pins. Rows y and y+16 are shifted together, with 1/16 scan.

## Interface
- `BITS`, 4: colour planes per channel, 1..8. Plane p uses channel bit `8-BITS+p`.
- `BASE_TICKS`, 8: display cycles for plane 0. Plane p displays for `BASE_TICKS<<p` cycles.
- `CLK12MHZ`, in, 1: clock.
- `resetn`, in, 1: synchronous, active-low reset. Clock is `CLK12MHZ`.
- `wr_enable`, in, 1: write strobe. Single-cycle, accepted every cycle, never stalls.
- `wr_addr_x`, in, 5: pixel column.
- `wr_addr_y`, in, 5: pixel row.
- `wr_rgb_data`, in, 24: `{R[7:0],G[7:0],B[7:0]}`.
- `PANEL_R0`, `PANEL_G0`, `PANEL_B0`, out, 1 each: colour data for the top row (y=r).
- `PANEL_R1`, `PANEL_G1`, `PANEL_B1`, out, 1 each: colour data for the bottom row (y=r+16).
- `PANEL_A`, `PANEL_B`, `PANEL_C`, `PANEL_D`, out, 1 each: row select `{D,C,B,A}=r`.
- `PANEL_CLK`, out, 1: shift clock. Data is sampled on the rising edge.
- `PANEL_STB`, out, 1: latch, active high.
- `PANEL_OE`, out, 1: output enable, active low.
- `frame_done`, out, 1: one-cycle pulse at the end of a full frame.

## Operation
- **Frame buffer**
  - Two banks of 512x24, selected by `y[4]`. Address within a bank is `{y[3:0],x}`.
  - Initialised to zero at configuration. Reset does not clear it.
- **Write/read collision:** a write to the pixel currently being read returns the old data (read-before-write). The new value appears on the next scan of that row and plane.
- **Scan counters:**
  - Row `r` is 0..15; plane `p` is 0..BITS-1.
  - Order: all planes of row r, then row r+1. Row 15 wraps to 0.
- **State machine:** FETCH -> SHIFT -> LATCH -> DISPLAY -> FETCH.
  - FETCH, 1 cycle: issue the read for x=0 to both banks.
  - SHIFT, 64 cycles, two per pixel x=0..31.
    - Phase 0: R/G/B outputs take the bits for pixel x, `PANEL_CLK`=0, and the read for x+1 is issued.
    - Phase 1: `PANEL_CLK`=1.
    - After x=31 phase 1, go to LATCH.
  - LATCH, 1 cycle: `PANEL_STB`=1, `{D,C,B,A}` updated to r, `PANEL_CLK`=0.
  - DISPLAY, `BASE_TICKS<<p` cycles with `PANEL_OE`=0. On exit, advance p; on p wrap, advance r.
- **PANEL_OE:** 1 in every state except DISPLAY.
- **Colour bits:** R0 = `top[16+8-BITS+p]`, G0 = `top[8+8-BITS+p]`, B0 = `top[8-BITS+p]`. R1/G1/B1 use the bottom bank identically.
- **frame_done:** asserted in the last DISPLAY cycle of r=15, p=BITS-1.

## Timing
- **Reset values:**
  - `PANEL_OE`=1, `PANEL_STB`=0, `PANEL_CLK`=0.
  - R/G/B outputs 0, `{D,C,B,A}`=0, `frame_done`=0.
  - State FETCH, r=0, p=0.
- **Reset mid-operation:** all outputs reach their reset values on the first clock with `resetn`=0. The scan restarts at FETCH r=0 p=0 on the first clock after release.
- **Cycles:**
  - Per plane: `66 + (BASE_TICKS<<p)` cycles.
  - Per frame at defaults: 16*(4*66+8*15) = 6144 cycles, about 1953 Hz.
- **Read latency:** 1 cycle, synchronous read. The pixel x read issued in the previous cycle drives the outputs in its phase 0.
- **Outputs:** all outputs are registered, with no combinational path from inputs.
- **Writes:** take effect in the buffer on the clock edge where `wr_enable`=1. Writes during reset are still performed.

## Structure
- **Package `ledpanel_pkg`** holds:
  - `PANEL_W`=32 and `HALF_ROWS`=16.
  - The scan state enum {FETCH, SHIFT, LATCH, DISPLAY}.
  - The RGB field offsets.
- **Sub-module `ledpanel_fb`:** dual-bank frame buffer with 1 write port and 1 read port per bank, read-before-write. It is inferred as block RAM.
- **Top FSM:** counters and output registers live in `ledpanel_scan`.

## Test plan
- **Reset values:** hold `resetn`=0 for 4 cycles, then release. Outputs are at reset values throughout. The first `PANEL_STB` pulse occurs on cycle 66 after release, with `{D,C,B,A}`=0.
- **Single pixel:** write (x=5, y=3) = `0xFF0000`, then capture the shift of row 3 for all planes.
  - R0=1 only on the 6th `PANEL_CLK` rising edge, in every plane.
  - G0, B0, R1, G1, B1 stay 0.
- **Bottom bank:** write (x=31, y=19) = `0x000080` with BITS=4.
  - B1=1 only in plane 3 of row 3, on the 32nd rising edge.
  - B0 stays 0.
- **Plane timing:** measure OE-low durations for row 0 at defaults. They must be 8, 16, 32 and 64 cycles, each preceded by exactly one STB pulse.
- **frame_done:** exactly one pulse every 6144 cycles. Row select sequence is 0..15, then wraps to 0.
- **Collision and mid-frame reset:**
  - Write (x=0, y=0) in the cycle its read is issued. The old value is shifted; the new value appears on the next scan of row 0, plane 0.
  - Assert `resetn`=0 during DISPLAY. `PANEL_OE`=1 on the next edge, and the frame buffer contents are preserved.
